// File: rtl/pieo_datatypes.sv
// pieo_datatypes: shared PIEO list sizing, element layout and op/state encodings
package pieo_datatypes;
  localparam int LIST_SIZE = 9;
  localparam int TIME_LOG = 14;
  localparam int ID_LOG = 3;
  typedef struct packed {
    logic [ID_LOG-1:0]   id;
    logic [TIME_LOG-1:0] send_time;
  } SublistElement;
  localparam int ELEM_W = $bits(SublistElement);
  localparam int OCC_W = $clog2(LIST_SIZE + 1);
  typedef enum logic [1:0] {OP_ENQ, OP_DEQ, OP_FLUSH} pieo_op_e;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} sched_state_e;
endpackage

// File: rtl/pieo_rr_arbiter.sv
// pieo_rr_arbiter: round-robin one-hot arbiter, pointer advances past the winner only on accept
module pieo_rr_arbiter #(
  parameter int N = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          accept,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx
);
  logic [PW-1:0] ptr;
  logic found;
  int idx;
  // walk offsets downward so the request closest to ptr is the last (winning) hit
  always_comb begin
    found = 1'b0;
    gnt_idx = '0;
    idx = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % N;
      if (req[idx]) begin
        found = 1'b1;
        gnt_idx = PW'(idx);
      end
    end
    gnt = found ? (N'(1) << gnt_idx) : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else if (accept && found) ptr <= (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + 1'b1;
endmodule

// File: rtl/pieo_op_scheduler.sv
// pieo_op_scheduler: serialises flush/deq/enq requests into one PIEO core op at a time
module pieo_op_scheduler
  import pieo_datatypes::*;
#(
  parameter int NUM_ENQ_PORTS = 4,
  parameter int DEQ_STARVE_LIMIT = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_ENQ_PORTS-1:0]        enq_valid,
  input  logic [NUM_ENQ_PORTS*ELEM_W-1:0] enq_data,
  output logic [NUM_ENQ_PORTS-1:0]        enq_ready,
  input  logic                            deq_valid,
  input  logic [TIME_LOG-1:0]             deq_curr_time,
  output logic                            deq_ready,
  output logic                            deq_rsp_valid,
  output logic                            deq_rsp_empty,
  output logic [ELEM_W-1:0]               deq_rsp_data,
  input  logic                            flush_req,
  output logic                            flush_done,
  output logic                            pieo_start,
  output pieo_op_e                        pieo_op,
  output logic [ELEM_W-1:0]               pieo_enq_data,
  output logic [TIME_LOG-1:0]             pieo_curr_time,
  input  logic                            pieo_ready,
  input  logic                            pieo_done,
  input  logic                            pieo_deq_valid,
  input  logic [ELEM_W-1:0]               pieo_deq_data,
  output logic [OCC_W-1:0]                occupancy,
  output logic                            err_spurious
);
  localparam int PW = (NUM_ENQ_PORTS > 1) ? $clog2(NUM_ENQ_PORTS) : 1;
  localparam int SW = $clog2(DEQ_STARVE_LIMIT + 1);
  sched_state_e state, next_state;
  logic [SW-1:0] starve_cnt;
  logic [NUM_ENQ_PORTS-1:0] enq_elig, gnt;
  logic [PW-1:0] gnt_idx;
  logic flush_pend, flush_any, idle, any_enq, deq_want, deq_short, deq_issue, enq_go, flush_go, done, done_deq;
  assign enq_elig = (occupancy == OCC_W'(LIST_SIZE)) ? '0 : enq_valid;
  pieo_rr_arbiter #(.N(NUM_ENQ_PORTS)) u_arb (
    .clk(clk), .rst_n(rst_n), .req(enq_elig), .accept(enq_go), .gnt(gnt), .gnt_idx(gnt_idx)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= next_state;
  always_comb
    next_state = (state == S_IDLE) ? ((flush_go || deq_issue || enq_go) ? S_ISSUE : S_IDLE) :
                 (state == S_ISSUE) ? S_WAIT :
                 (state == S_WAIT && !pieo_done) ? S_WAIT : S_IDLE;
  // the empty-list dequeue is answered locally, so it does not wait for the core to be ready
  always_comb begin
    idle = state == S_IDLE;
    any_enq = |enq_elig;
    flush_any = flush_pend || flush_req;
    deq_want = deq_valid && (starve_cnt < SW'(DEQ_STARVE_LIMIT) || !any_enq);
    deq_ready = idle && !flush_any && deq_want && (pieo_ready || occupancy == '0);
    deq_short = deq_ready && occupancy == '0;
    deq_issue = deq_ready && occupancy != '0;
    flush_go = idle && pieo_ready && flush_any;
    enq_go = idle && pieo_ready && !flush_any && !deq_want && any_enq;
    enq_ready = enq_go ? gnt : '0;
    pieo_start = state == S_ISSUE;
    done = state == S_WAIT && pieo_done;
    done_deq = done && pieo_op == OP_DEQ;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pieo_op <= OP_ENQ;
      pieo_enq_data <= '0;
      pieo_curr_time <= '0;
      deq_rsp_valid <= 1'b0;
      deq_rsp_empty <= 1'b0;
      deq_rsp_data <= '0;
      flush_done <= 1'b0;
      flush_pend <= 1'b0;
      err_spurious <= 1'b0;
      occupancy <= '0;
      starve_cnt <= '0;
    end else begin
      flush_pend <= flush_any && !flush_go;
      err_spurious <= err_spurious || (pieo_done && state != S_WAIT);
      deq_rsp_valid <= deq_short || done_deq;
      deq_rsp_empty <= deq_short || (done_deq && !pieo_deq_valid);
      deq_rsp_data <= (done_deq && pieo_deq_valid) ? pieo_deq_data : '0;
      flush_done <= done && pieo_op == OP_FLUSH;
      if (flush_go || deq_issue || enq_go) pieo_op <= flush_go ? OP_FLUSH : deq_issue ? OP_DEQ : OP_ENQ;
      if (enq_go) pieo_enq_data <= enq_data[gnt_idx*ELEM_W +: ELEM_W];
      if (deq_issue) pieo_curr_time <= deq_curr_time;
      if (done) occupancy <= (pieo_op == OP_FLUSH) ? '0 :
                             (pieo_op == OP_ENQ) ? occupancy + 1'b1 : occupancy - OCC_W'(pieo_deq_valid);
      starve_cnt <= enq_go ? '0 :
                    (deq_ready && any_enq && starve_cnt < SW'(DEQ_STARVE_LIMIT)) ? starve_cnt + 1'b1 : starve_cnt;
    end
endmodule

// File: tb/tb_pieo_op_scheduler.sv
// tb_pieo_op_scheduler: directed vector table plus hand sequences against a behavioural PIEO core
module tb_pieo_op_scheduler;
  import pieo_datatypes::*;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] enq_valid, enq_ready;
  logic [4*ELEM_W-1:0] enq_data;
  logic deq_valid, deq_ready, deq_rsp_valid, deq_rsp_empty;
  logic [TIME_LOG-1:0] deq_curr_time, pieo_curr_time;
  logic [ELEM_W-1:0] deq_rsp_data, pieo_enq_data, pieo_deq_data;
  logic flush_req, flush_done, pieo_start, pieo_ready, pieo_done, pieo_deq_valid, err_spurious;
  pieo_op_e pieo_op;
  logic [OCC_W-1:0] occupancy;
  pieo_op_scheduler dut (
    .clk(clk), .rst_n(rst_n), .enq_valid(enq_valid), .enq_data(enq_data), .enq_ready(enq_ready),
    .deq_valid(deq_valid), .deq_curr_time(deq_curr_time), .deq_ready(deq_ready),
    .deq_rsp_valid(deq_rsp_valid), .deq_rsp_empty(deq_rsp_empty), .deq_rsp_data(deq_rsp_data),
    .flush_req(flush_req), .flush_done(flush_done), .pieo_start(pieo_start), .pieo_op(pieo_op),
    .pieo_enq_data(pieo_enq_data), .pieo_curr_time(pieo_curr_time), .pieo_ready(pieo_ready),
    .pieo_done(pieo_done), .pieo_deq_valid(pieo_deq_valid), .pieo_deq_data(pieo_deq_data),
    .occupancy(occupancy), .err_spurious(err_spurious)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0]          enq;
    logic                deq;
    logic [TIME_LOG-1:0] t;
    logic                ret_v;
    logic [ELEM_W-1:0]   ret_d;
    logic [3:0]          gnt;
    logic [OCC_W-1:0]    occ_b;
    logic [OCC_W-1:0]    occ_a;
    logic                empty;
  } vec_t;
  vec_t tbl [14];
  logic [ELEM_W-1:0] pdata [4];
  int n_chk = 0, n_fail = 0;
  int n_starts = 0, n_done = 0, core_lat = 0, cnt = 0;
  logic busy = 1'b0, spur_done = 1'b0, core_ret_valid = 1'b0;
  logic [ELEM_W-1:0] core_ret_data = '0, last_data = '0;
  logic [TIME_LOG-1:0] last_time = '0;
  pieo_op_e last_op = OP_ENQ, cur_op = OP_ENQ;
  // behavioural core: takes a start, answers after core_lat extra cycles
  always @(negedge clk) begin
    if (!rst_n) begin
      busy = 1'b0; cnt = 0; pieo_done = 1'b0; pieo_deq_valid = 1'b0; pieo_deq_data = '0; pieo_ready = 1'b1;
    end else begin
      pieo_done = spur_done; pieo_deq_valid = 1'b0; pieo_deq_data = '0;
      if (busy) begin
        if (cnt == 0) begin
          pieo_done = 1'b1; busy = 1'b0; n_done++;
          if (cur_op == OP_DEQ) begin
            pieo_deq_valid = core_ret_valid;
            pieo_deq_data = core_ret_valid ? core_ret_data : '0;
          end
        end else cnt--;
      end
      if (pieo_start) begin
        busy = 1'b1; cnt = core_lat; n_starts++;
        last_op = pieo_op; cur_op = pieo_op; last_data = pieo_enq_data; last_time = pieo_curr_time;
      end
      pieo_ready = !busy;
    end
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(negedge clk); #2;
  endtask
  task automatic wait_grant();
    for (int i = 0; i < 40; i++) begin
      #1;
      if (deq_ready || enq_ready != 4'h0) break;
      step();
    end
    check("grant_seen", 32'(deq_ready || enq_ready != 4'h0), 1);
  endtask
  task automatic run_vec(input vec_t v);
    int s0, d0;
    logic [ELEM_W-1:0] exp_d;
    s0 = n_starts; d0 = n_done; exp_d = '0;
    enq_valid = v.enq; deq_valid = v.deq; deq_curr_time = v.t; core_ret_valid = v.ret_v; core_ret_data = v.ret_d;
    wait_grant();
    check("occ_before", 32'(occupancy), 32'(v.occ_b));
    check("enq_ready", 32'(enq_ready), 32'(v.gnt));
    check("deq_ready", 32'(deq_ready), 32'(v.deq));
    step();
    enq_valid = 4'h0; deq_valid = 1'b0;
    if (v.deq) begin
      for (int i = 0; i < 40; i++) begin
        if (deq_rsp_valid) break;
        step();
      end
      check("rsp_valid", 32'(deq_rsp_valid), 1);
      check("rsp_empty", 32'(deq_rsp_empty), 32'(v.empty));
      if (!v.empty) check("rsp_data", 32'(deq_rsp_data), 32'(v.ret_d));
      check("deq_starts", 32'(n_starts - s0), 32'(v.occ_b != '0));
      if (v.occ_b != '0) check("core_time", 32'(last_time), 32'(v.t));
    end else begin
      for (int i = 0; i < 40; i++) begin
        if (n_done != d0) break;
        step();
      end
      check("enq_done", 32'(n_done != d0), 1);
      step();
      for (int i = 0; i < 4; i++) if (v.gnt[i]) exp_d = pdata[i];
      check("enq_starts", 32'(n_starts - s0), 1);
      check("core_op", 32'(last_op), 32'(OP_ENQ));
      check("core_data", 32'(last_data), 32'(exp_d));
    end
    check("occ_after", 32'(occupancy), 32'(v.occ_a));
  endtask
  task automatic starve_round();
    enq_valid = 4'b0100; deq_valid = 1'b1; core_ret_valid = 1'b0;
    for (int k = 0; k < 9; k++) begin
      wait_grant();
      check($sformatf("starve_grant%0d", k), 32'({deq_ready, enq_ready}), (k < 8) ? 32'h10 : 32'h04);
      step();
    end
    enq_valid = 4'h0; deq_valid = 1'b0;
    for (int i = 0; i < 40 && occupancy != 4'd9; i++) step();
    check("starve_occ", 32'(occupancy), 9);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int s0, hits;
    rst_n = 1'b0; enq_valid = 4'h0; deq_valid = 1'b0; deq_curr_time = '0; flush_req = 1'b0;
    pdata[0] = 17'h00A01; pdata[1] = 17'h00B12; pdata[2] = 17'h10C23; pdata[3] = 17'h1FD34;
    enq_data = {pdata[3], pdata[2], pdata[1], pdata[0]};
    tbl[0]  = '{4'h0, 1'b1, 14'h0001, 1'b0, 17'h00000, 4'h0, 4'd0, 4'd0, 1'b1};
    tbl[1]  = '{4'hF, 1'b0, 14'h0000, 1'b0, 17'h00000, 4'h1, 4'd0, 4'd1, 1'b0};
    tbl[2]  = '{4'hF, 1'b0, 14'h0000, 1'b0, 17'h00000, 4'h2, 4'd1, 4'd2, 1'b0};
    tbl[3]  = '{4'hF, 1'b0, 14'h0000, 1'b0, 17'h00000, 4'h4, 4'd2, 4'd3, 1'b0};
    tbl[4]  = '{4'hF, 1'b0, 14'h0000, 1'b0, 17'h00000, 4'h8, 4'd3, 4'd4, 1'b0};
    tbl[5]  = '{4'hF, 1'b0, 14'h0000, 1'b0, 17'h00000, 4'h1, 4'd4, 4'd5, 1'b0};
    tbl[6]  = '{4'hF, 1'b0, 14'h0000, 1'b0, 17'h00000, 4'h2, 4'd5, 4'd6, 1'b0};
    tbl[7]  = '{4'hF, 1'b0, 14'h0000, 1'b0, 17'h00000, 4'h4, 4'd6, 4'd7, 1'b0};
    tbl[8]  = '{4'hF, 1'b0, 14'h0000, 1'b0, 17'h00000, 4'h8, 4'd7, 4'd8, 1'b0};
    tbl[9]  = '{4'hF, 1'b0, 14'h0000, 1'b0, 17'h00000, 4'h1, 4'd8, 4'd9, 1'b0};
    tbl[10] = '{4'h0, 1'b1, 14'h0003, 1'b1, 17'h0ABCD, 4'h0, 4'd9, 4'd8, 1'b0};
    tbl[11] = '{4'hF, 1'b0, 14'h0000, 1'b0, 17'h00000, 4'h2, 4'd8, 4'd9, 1'b0};
    tbl[12] = '{4'h0, 1'b1, 14'h2000, 1'b0, 17'h00000, 4'h0, 4'd9, 4'd9, 1'b1};
    tbl[13] = '{4'h0, 1'b1, 14'h0007, 1'b1, 17'h15555, 4'h0, 4'd9, 4'd8, 1'b0};
    repeat (3) @(negedge clk);
    #2;
    check("rst_occ", 32'(occupancy), 0);
    check("rst_start", 32'(pieo_start), 0);
    check("rst_rsp", 32'({deq_rsp_valid, deq_rsp_empty, flush_done, err_spurious}), 0);
    check("rst_op", 32'(pieo_op), 0);
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 10; i++) run_vec(tbl[i]);
    // list full: enq held off, no core op
    s0 = n_starts; enq_valid = 4'hF;
    for (int i = 0; i < 4; i++) begin
      #1; check("full_enq_ready", 32'(enq_ready), 0);
      step();
    end
    check("full_no_start", 32'(n_starts - s0), 0);
    enq_valid = 4'h0;
    for (int i = 10; i < 14; i++) run_vec(tbl[i]);
    starve_round();
    run_vec('{4'h0, 1'b1, 14'h0011, 1'b1, 17'h00042, 4'h0, 4'd9, 4'd8, 1'b0});
    starve_round();
    // flush requested while an enqueue is in flight
    run_vec('{4'h0, 1'b1, 14'h0012, 1'b1, 17'h00043, 4'h0, 4'd9, 4'd8, 1'b0});
    s0 = n_starts; enq_valid = 4'b0001;
    wait_grant();
    check("fl_enq_gnt", 32'(enq_ready), 1);
    step();
    enq_valid = 4'h0; flush_req = 1'b1;
    step();
    step();
    flush_req = 1'b0;
    #1; check("fl_occ_enq", 32'(occupancy), 9);
    for (int i = 0; i < 40; i++) begin
      if (flush_done) break;
      step();
    end
    check("flush_done", 32'(flush_done), 1);
    check("fl_occ", 32'(occupancy), 0);
    check("fl_op", 32'(last_op), 32'(OP_FLUSH));
    repeat (5) step();
    check("fl_starts", 32'(n_starts - s0), 2);
    // spurious done in IDLE
    s0 = n_starts; spur_done = 1'b1;
    step();
    spur_done = 1'b0;
    step();
    check("err_spurious", 32'(err_spurious), 1);
    check("spur_state", 32'({deq_rsp_valid, flush_done, occupancy}), 0);
    check("spur_no_start", 32'(n_starts - s0), 0);
    run_vec('{4'b0001, 1'b0, 14'h0000, 1'b0, 17'h00000, 4'h1, 4'd0, 4'd1, 1'b0});
    // reset while a dequeue waits on the core
    core_lat = 6; core_ret_valid = 1'b1; deq_valid = 1'b1; deq_curr_time = 14'h0009;
    wait_grant();
    check("rw_deq_ready", 32'(deq_ready), 1);
    step();
    deq_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check("rw_occ", 32'(occupancy), 0);
    check("rw_err", 32'(err_spurious), 0);
    check("rw_start_op", 32'({pieo_start, pieo_op}), 0);
    step();
    rst_n = 1'b1; core_lat = 0; hits = 0;
    for (int i = 0; i < 10; i++) begin
      if (deq_rsp_valid) hits++;
      step();
    end
    check("rw_no_rsp", 32'(hits), 0);
    run_vec('{4'h0, 1'b1, 14'h0001, 1'b0, 17'h00000, 4'h0, 4'd0, 4'd0, 1'b1});
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
